// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file.
// Holds the clear/run state encoding and the address-width helper.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int XLEN_DEF     = 32;
    localparam int DEPTH_DEF    = 32;
    localparam int ZERO_REG_DEF = 1;
    localparam int BYPASS_DEF   = 1;

    function automatic int addr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Register-file port bundle: one write port, two combinational read ports, clear request.
// No flow control beyond ready, which is low while the clear sequence runs.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = addr_w(DEPTH);

    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr1;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            clr_req;
    logic            ready;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, clr_req,
        input  rdata1, rdata2, ready
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, clr_req,
        output rdata1, rdata2, ready
    );

endinterface

// File: rtl/reg_file_clear_ctrl.sv
// Clear/run sequencer: walks cnt over every register for DEPTH cycles, then enters RUN.
// ready is registered; a clear request in RUN restarts the walk at register 0.
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = addr_w(DEPTH_DEF)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_req_i,
    output state_e        state_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          ready_o
);

    // One spare bit so a power-of-two DEPTH never wraps before the last register.
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    state_e      state_q;
    logic [AW:0] cnt_q;
    logic [AW:0] cnt_d;
    logic        ready_q;

    assign cnt_d = cnt_q + (AW+1)'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RUN: begin
                    if (clr_req_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign state_o    = state_q;
    assign clr_addr_o = cnt_q[AW-1:0];
    assign ready_o    = ready_q;

endmodule

// File: rtl/reg_file_mp.sv
// Register file, one write / two read ports, optional zero register and write-to-read bypass.
// Reads are combinational; writes land at the next edge and are dropped while clearing.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int BYPASS   = BYPASS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    reg_file_mp_if.slave   bus
);

    localparam int          AW      = addr_w(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [XLEN-1:0] regs_q [DEPTH];

    state_e          state;
    logic [AW-1:0]   clr_addr;
    logic            ready;

    logic            fwd_vld;
    logic            wr_en;
    logic            port_we;
    logic [AW-1:0]   port_addr;
    logic [XLEN-1:0] port_dat;

    logic [AW-1:0]   raddr [2];
    logic [XLEN-1:0] rdata [2];

    reg_file_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ctrl (
        .clk_i      (clk),
        .reset_i    (reset),
        .clr_req_i  (bus.clr_req),
        .state_o    (state),
        .clr_addr_o (clr_addr),
        .ready_o    (ready)
    );

    assign fwd_vld = (state == RUN) && bus.we && !bus.clr_req && addr_ok(bus.waddr);
    assign wr_en   = fwd_vld && !reset;

    // Clear sequence and normal writes share the single storage write port.
    always_comb begin
        port_we   = wr_en;
        port_addr = bus.waddr;
        port_dat  = bus.wdata;
        if (state == CLEAR) begin
            port_we   = 1'b1;
            port_addr = clr_addr;
            port_dat  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (port_we) begin
            regs_q[port_addr] <= port_dat;
        end
    end

    assign raddr[0] = bus.raddr1;
    assign raddr[1] = bus.raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdata[p] = '0;
            if ((state == RUN) && addr_ok(raddr[p])) begin
                if ((BYPASS != 0) && fwd_vld && (bus.waddr == raddr[p])) begin
                    rdata[p] = bus.wdata;
                end else begin
                    rdata[p] = regs_q[raddr[p]];
                end
            end
        end
    end

    assign bus.rdata1 = rdata[0];
    assign bus.rdata2 = rdata[1];
    assign bus.ready  = ready;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two configurations share one stimulus stream
// (A: DEPTH 32, zero reg, bypass; B: DEPTH 24, no zero reg, no bypass).
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          we;
    logic          clr_req;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [31:0]   wdata;

    reg_file_mp_if #(.XLEN(32), .DEPTH(32)) ifa ();
    reg_file_mp_if #(.XLEN(32), .DEPTH(24)) ifb ();

    assign ifa.we = we;           assign ifb.we = we;
    assign ifa.clr_req = clr_req; assign ifb.clr_req = clr_req;
    assign ifa.waddr = waddr;     assign ifb.waddr = waddr;
    assign ifa.wdata = wdata;     assign ifb.wdata = wdata;
    assign ifa.raddr1 = raddr1;   assign ifb.raddr1 = raddr1;
    assign ifa.raddr2 = raddr2;   assign ifb.raddr2 = raddr2;

    reg_file_mp #(.XLEN(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .bus(ifa));
    reg_file_mp #(.XLEN(32), .DEPTH(24), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .bus(ifb));

    logic        rdy [2];
    logic [31:0] r1 [2];
    logic [31:0] r2 [2];
    assign rdy[0] = ifa.ready;  assign rdy[1] = ifb.ready;
    assign r1[0]  = ifa.rdata1; assign r1[1]  = ifb.rdata1;
    assign r2[0]  = ifa.rdata2; assign r2[1]  = ifb.rdata2;

    int checks = 0;
    int errors = 0;

    // Reference model: a clear is "busy for DEPTH cycles, then everything is zero".
    int          depth_m [2] = '{32, 24};
    bit          zr_m    [2] = '{1'b1, 1'b0};
    bit          byp_m   [2] = '{1'b1, 1'b0};
    logic [31:0] mem     [2][32];
    int          left    [2];

    function automatic bit wr_valid(int d, logic [AW-1:0] a);
        return (int'(a) < depth_m[d]) && !(zr_m[d] && a == 0);
    endfunction

    function automatic logic [31:0] model_rd(int d, logic [AW-1:0] a);
        if (left[d] > 0) return 32'h0;
        if (!wr_valid(d, a)) return 32'h0;
        if (byp_m[d] && we && !clr_req && a == waddr) return wdata;
        return mem[d][a];
    endfunction

    task automatic start_clear(int d);
        left[d] = depth_m[d];
        for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) start_clear(d);
            else if (left[d] > 0) left[d] = left[d] - 1;
            else if (clr_req) start_clear(d);
            else if (we && wr_valid(d, waddr)) mem[d][waddr] = wdata;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check(d == 0 ? "ready_a" : "ready_b", 32'(rdy[d]), 32'(left[d] == 0));
            check(d == 0 ? "rd1_a" : "rd1_b", r1[d], model_rd(d, raddr1));
            check(d == 0 ? "rd2_a" : "rd2_b", r2[d], model_rd(d, raddr2));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Counts cycles from now until each ready rises; bounded at 100.
    task automatic wait_ready(string name, int exp_a, int exp_b);
        int ca = -1;
        int cb = -1;
        for (int i = 0; i < 100; i++) begin
            if (rdy[0] === 1'b1 && ca < 0) ca = i;
            if (rdy[1] === 1'b1 && cb < 0) cb = i;
            if (ca >= 0 && cb >= 0) break;
            cycle();
        end
        check({name, "_a"}, 32'(ca), 32'(exp_a));
        check({name, "_b"}, 32'(cb), 32'(exp_b));
    endtask

    task automatic read_all();
        we = 1'b0; clr_req = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            cycle();
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] a1, a2, b1, b2;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[4] = '{1'b1, 5'd30, 32'h12345678, 5'd30, 5'd30, 32'h12345678, 32'h12345678, 32'h0, 32'h0};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd30, 32'h12345678, 32'h12345678, 32'h0, 32'h0};
        tbl[6] = '{1'b1, 5'd23, 32'h0A0A0A0A, 5'd23, 5'd5,  32'h0A0A0A0A, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd23, 5'd31, 32'h0A0A0A0A, 32'h0, 32'h0A0A0A0A, 32'h0};

        reset = 1'b1; we = 1'b0; clr_req = 1'b0;
        waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = 5'd0;
        start_clear(0);
        start_clear(1);
        @(posedge clk);
        #1;
        cycle();
        check("reset_ready_a", 32'(rdy[0]), 32'h0);
        check("reset_rd1_a", r1[0], 32'h0);
        reset = 1'b0;
        wait_ready("clr_len_reset", 32, 24);
        read_all();

        for (int i = 0; i < 8; i++) begin
            we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
            raddr1 = tbl[i].ra1; raddr2 = tbl[i].ra2;
            #2;
            check($sformatf("tbl%0d_a1", i), r1[0], tbl[i].a1);
            check($sformatf("tbl%0d_a2", i), r2[0], tbl[i].a2);
            check($sformatf("tbl%0d_b1", i), r1[1], tbl[i].b1);
            check($sformatf("tbl%0d_b2", i), r2[1], tbl[i].b2);
            cycle();
        end

        // Fill, then a clear request that collides with a write.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i); raddr1 = 5'(i); raddr2 = 5'(i - 1);
            cycle();
        end
        we = 1'b1; waddr = 5'd7; wdata = 32'h77; raddr1 = 5'd7; raddr2 = 5'd3;
        clr_req = 1'b1;
        cycle();
        we = 1'b0; clr_req = 1'b0;
        wait_ready("clr_len_req", 32, 24);
        read_all();

        // Reset ten cycles into a clear, with writes and clear requests along the way.
        clr_req = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            clr_req = i[0]; we = 1'b1; waddr = 5'd3; wdata = 32'h33;
            cycle();
        end
        clr_req = 1'b0; we = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        wait_ready("clr_len_rst_mid", 32, 24);
        raddr1 = 5'd3;
        #1;
        check("we_in_clear_a", r1[0], 32'h0);
        check("we_in_clear_b", r1[1], 32'h0);

        // Clear requests held during a clear must not restart it.
        clr_req = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) cycle();
        clr_req = 1'b0;
        wait_ready("clr_len_ignore", 27, 19);

        for (int i = 0; i < 1500; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            clr_req = ($urandom_range(0, 59) == 0);
            we      = 1'($urandom_range(0, 1));
            waddr   = 5'($urandom);
            wdata   = $urandom;
            raddr1  = $urandom_range(0, 1) ? waddr : 5'($urandom);
            raddr2  = $urandom_range(0, 2) == 0 ? waddr : 5'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, 32, data width in bits.
REQ-002 Parameter DEPTH, 32, number of registers, 2..1024, not necessarily a power of two.
REQ-003 Parameter ZERO_REG, 1, when 1 register 0 SHALL read 0 and ignore writes.
REQ-004 Parameter BYPASS, 1, when 1 a same-cycle write SHALL be forwarded to matching read ports.
REQ-005 Derived constant AW = max(1, clog2(DEPTH)), address width.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  AW  write address (rd).
REQ-010 wdata  input  XLEN  write data.
REQ-011 raddr1, raddr2  input  AW  read addresses (rs1, rs2).
REQ-012 rdata1, rdata2  output  XLEN  read data, combinational from address.
REQ-013 clr_req  input  1  request a full clear of all registers.
REQ-014 ready  output  1  high when in RUN and writes are accepted.

Function
REQ-015 FSM SHALL have two states: CLEAR and RUN.
REQ-016 CLEAR: each cycle SHALL write 0 to regs[cnt] and increment cnt; the cycle cnt==DEPTH-1 is written, next state SHALL be RUN.
REQ-017 Full clear SHALL take exactly DEPTH cycles; ready SHALL be 0 throughout CLEAR and 1 throughout RUN.
REQ-018 RUN: if we=1, clr_req=0 and waddr valid, regs[waddr] SHALL take wdata at the rising edge.
REQ-019 Valid write address: waddr < DEPTH and not (ZERO_REG=1 and waddr=0); invalid writes SHALL be silently dropped.
REQ-020 rdataN SHALL equal regs[raddrN] combinationally; raddrN >= DEPTH SHALL read 0; raddrN=0 with ZERO_REG=1 SHALL read 0.
REQ-021 BYPASS=1: when in RUN, we=1, clr_req=0, valid waddr and waddr==raddrN, rdataN SHALL equal wdata in that same cycle; both ports may bypass simultaneously.
REQ-022 BYPASS=0: rdataN SHALL reflect the written value only from the cycle after the write edge.
REQ-023 During CLEAR rdata1 and rdata2 SHALL be 0 regardless of address or register contents.
REQ-024 clr_req=1 in RUN SHALL move FSM to CLEAR with cnt=0 at the next edge; a simultaneous write SHALL be dropped.
REQ-025 clr_req in CLEAR SHALL be ignored; the sequence continues without restart.
REQ-026 we in CLEAR SHALL be ignored; no write is queued or replayed.
REQ-027 cnt SHALL be AW+1 bits wide so DEPTH=2^AW does not wrap before termination.

Reset
REQ-028 reset=1 at a rising edge SHALL set state=CLEAR, cnt=0, ready=0, overriding we and clr_req.
REQ-029 reset during CLEAR SHALL restart the clear at register 0.
REQ-030 Register contents SHALL NOT be reset in parallel; zeroing occurs only via the CLEAR sequence.
REQ-031 Outputs after reset: ready=0, rdata1=rdata2=0 until RUN.

Structure
REQ-032 Package reg_file_pkg SHALL hold the FSM state enum (CLEAR, RUN) and default parameter constants.
REQ-033 Sub-module reg_file_clear_ctrl SHALL contain the FSM, cnt and ready; reg_file_mp SHALL contain storage, read muxing and bypass.
REQ-034 Storage SHALL be a single array of DEPTH x XLEN with one write port; the clear sequence and normal writes SHALL share that port via a mux.

Verification
REQ-035 Release reset, DEPTH=32 -> ready=0 for exactly 32 cycles, then 1; all reads return 0.
REQ-036 RUN, write waddr=5 wdata=0xDEADBEEF, raddr1=5 same cycle -> rdata1=0xDEADBEEF same cycle (BYPASS=1), next cycle (BYPASS=0).
REQ-037 Write waddr=0 wdata=0xFFFFFFFF, ZERO_REG=1 -> rdata1 at raddr1=0 stays 0 in that and subsequent cycles.
REQ-038 Fill regs 1..31 with index value, assert clr_req with we=1 waddr=7 wdata=0x77 -> write dropped, ready low 32 cycles, afterwards all reads 0.
REQ-039 Assert reset at cycle 10 of a clear, DEPTH=32 -> ready rises exactly 32 cycles after reset deasserts.
REQ-040 DEPTH=24, write waddr=30 and read raddr2=30 -> no storage change, rdata2=0; we asserted during CLEAR -> register unchanged after RUN.
